// File: rtl/pixel_writer_pkg.sv
// Shared types and grid constants for the pixel writer.
// Op 2'b00 is NOP, or OUTLINE when PIXEL_WRITER_OUTLINE_EN is defined.
package pixel_writer_pkg;

    localparam int GRID_W = 40;
    localparam int GRID_H = 30;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_POINT = 2'b01,
        OP_RECT  = 2'b10,
        OP_FILL  = 2'b11
    } op_t;

    localparam op_t OP_OUTLINE = OP_NOP;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/pixel_writer_rect_scanner.sv
// Row-major x/y counter pair over a loaded rectangle.
// Flags the last pixel and whether the current pixel lies on the border.
module rect_scanner #(
    parameter int X_W = 10,
    parameter int Y_W = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_step,
    input  logic           i_outline,
    input  logic [X_W-1:0] i_xl,
    input  logic [Y_W-1:0] i_yl,
    input  logic [X_W-1:0] i_xh,
    input  logic [Y_W-1:0] i_yh,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_last,
    output logic           o_hit
);

    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [X_W-1:0] r_xl;
    logic [Y_W-1:0] r_yl;
    logic [X_W-1:0] r_xh;
    logic [Y_W-1:0] r_yh;
    logic           w_edge;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x  <= '0;
            r_y  <= '0;
            r_xl <= '0;
            r_yl <= '0;
            r_xh <= '0;
            r_yh <= '0;
        end else if (i_load) begin
            r_x  <= i_xl;
            r_y  <= i_yl;
            r_xl <= i_xl;
            r_yl <= i_yl;
            r_xh <= i_xh;
            r_yh <= i_yh;
        end else if (i_step) begin
            if (r_x == r_xh) begin
                r_x <= r_xl;
                r_y <= r_y + Y_W'(1);
            end else begin
                r_x <= r_x + X_W'(1);
            end
        end
    end

    assign w_edge = (r_x == r_xl) || (r_x == r_xh) ||
                    (r_y == r_yl) || (r_y == r_yh);

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == r_xh) && (r_y == r_yh);
    assign o_hit  = !i_outline || w_edge;

endmodule

// File: rtl/pixel_writer.sv
// Expands point/rect/fill commands into one pixel write per clock.
// PIXEL_WRITER_OUTLINE_EN turns op 2'b00 into a border-only rectangle.
module pixel_writer
    import pixel_writer_pkg::*;
#(
    parameter int WIDTH  = GRID_W,
    parameter int HEIGHT = GRID_H,
    parameter int X_W    = 10,
    parameter int Y_W    = 9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [1:0]     cmd_op,
    input  logic [X_W-1:0] cmd_x0,
    input  logic [Y_W-1:0] cmd_y0,
    input  logic [X_W-1:0] cmd_x1,
    input  logic [Y_W-1:0] cmd_y1,
    input  logic           cmd_data,
    output logic           wr_en,
    output logic [X_W-1:0] wr_x,
    output logic [Y_W-1:0] wr_y,
    output logic           wr_data,
    output logic           busy,
    output logic           done
);

    localparam logic [X_W-1:0] XMAX = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0] YMAX = Y_W'(HEIGHT - 1);

    state_t         r_state;
    state_t         w_state_next;
    logic           r_data;
    logic           w_outline;
    logic           w_accept;
    logic           w_load;
    logic           w_step;
    logic           w_last;
    logic           w_hit;
    logic           w_has_pix;
    logic           w_drop;
    op_t            w_op;
    logic [X_W-1:0] w_x1;
    logic [Y_W-1:0] w_y1;
    logic [X_W-1:0] w_xl;
    logic [X_W-1:0] w_xh;
    logic [Y_W-1:0] w_yl;
    logic [Y_W-1:0] w_yh;

    assign w_op     = op_t'(cmd_op);
    assign w_accept = cmd_valid && cmd_ready;

    // POINT reuses the rect path as a degenerate 1x1 rectangle
    always_comb begin
        w_x1 = (w_op == OP_POINT) ? cmd_x0 : cmd_x1;
        w_y1 = (w_op == OP_POINT) ? cmd_y0 : cmd_y1;
        w_xl = (cmd_x0 < w_x1) ? cmd_x0 : w_x1;
        w_xh = (cmd_x0 < w_x1) ? w_x1 : cmd_x0;
        w_yl = (cmd_y0 < w_y1) ? cmd_y0 : w_y1;
        w_yh = (cmd_y0 < w_y1) ? w_y1 : cmd_y0;
        if (w_xh > XMAX) w_xh = XMAX;
        if (w_yh > YMAX) w_yh = YMAX;
        if (w_op == OP_FILL) begin
            w_xl = '0;
            w_yl = '0;
            w_xh = XMAX;
            w_yh = YMAX;
        end
        w_drop = (w_xl > XMAX) || (w_yl > YMAX);
    end

`ifdef PIXEL_WRITER_OUTLINE_EN
    logic r_outline;

    assign w_has_pix = 1'b1;
    assign w_outline = r_outline;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_outline <= 1'b0;
        end else if (w_accept) begin
            r_outline <= (w_op == OP_OUTLINE);
        end
    end
`else
    assign w_has_pix = (w_op != OP_NOP);
    assign w_outline = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_has_pix && !w_drop) begin
                        w_state_next = SCAN;
                        w_load       = 1'b1;
                    end else begin
                        w_state_next = FINISH;
                    end
                end
            end
            SCAN: begin
                if (w_last) w_state_next = FINISH;
                else        w_step       = 1'b1;
            end
            FINISH:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_data  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) r_data <= cmd_data;
        end
    end

    rect_scanner #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_outline (w_outline),
        .i_xl      (w_xl),
        .i_yl      (w_yl),
        .i_xh      (w_xh),
        .i_yh      (w_yh),
        .o_x       (wr_x),
        .o_y       (wr_y),
        .o_last    (w_last),
        .o_hit     (w_hit)
    );

    assign cmd_ready = (r_state == IDLE) && !reset;
    assign busy      = (r_state == SCAN);
    assign done      = (r_state == FINISH);
    assign wr_en     = (r_state == SCAN) && w_hit;
    assign wr_data   = r_data;

endmodule
